ofifo_drain: RTL and testbench
==============================

// Module: ofifo_drain
// PURPOSE
// - Consumer side of the output FIFO. Waits for a complete row of column psums (fifo_valid = all columns non-empty).
// - Pops one row via fifo_rd and captures it after a fixed read latency.
// - Optionally applies per-lane ReLU, then writes the row to the psum SRAM at an auto-incrementing address.
// - Sits between the ofifo and the psum SRAM; a core controller starts it and sees done.
// PARAMETERS
// - col     8   number of columns (lanes) per row
// - bw      16  bits per lane (signed psum)
// - addr_w  11  SRAM address width
// - rd_lat  2   cycles from fifo_rd high to fifo_out valid (registered rd_en + FIFO output)
// PORTS
// - clk         in   1           rising-edge clock
// - reset       in   1           asynchronous, active-low reset
// - start       in   1           1-cycle pulse, begin a drain job (sampled only in IDLE)
// - base_addr   in   addr_w      first SRAM address, sampled at start
// - num_words   in   addr_w      rows to move, sampled at start
// - relu_en     in   1           sampled at start; 1 = clamp negative lanes to 0
// - fifo_valid  in   1           ofifo o_valid
// - fifo_rd     out  1           ofifo rd, registered
// - fifo_out    in   bw*col      ofifo out
// - sram_cen    out  1           SRAM chip enable, active-low, registered
// - sram_wen    out  1           SRAM write enable, active-low, registered
// - sram_a      out  addr_w      SRAM address, registered
// - sram_d      out  bw*col      SRAM write data, registered
// - busy        out  1           high from start accept until DONE exits
// - done        out  1           1-cycle pulse when the job completes
// BEHAVIOUR
// - Reset values: fifo_rd=0, sram_cen=1, sram_wen=1, sram_a=0, sram_d=0, busy=0, done=0. FSM=IDLE; counters=0.
// - IDLE: on start, latch base_addr/num_words/relu_en and set busy.
//   - num_words==0 -> DONE.
//   - otherwise -> WAIT.
// - WAIT: stay while fifo_valid=0. When fifo_valid=1 -> ISSUE.
// - ISSUE: fifo_rd=1 for exactly one cycle -> LAT; latency counter loads rd_lat.
// - LAT: count down rd_lat cycles. On the cycle fifo_out is valid, capture it into the row register -> WRITE.
// - WRITE: one cycle with sram_cen=0, sram_wen=0, sram_a=addr, sram_d=processed row. Then addr+=1, cnt+=1.
//   - cnt+1==num_words -> DONE, else WAIT.
// - DONE: done=1 for one cycle, busy=0 next cycle, -> IDLE.
// - At most one read outstanding; a new fifo_rd is never issued before the previous row is written.
//   - Rationale: the FIFO's o_valid lags the pop.
//   - Throughput: 1 row per rd_lat+3 cycles when the FIFO is kept non-empty.
// - ReLU: per bw-bit lane, signed. If relu_en and MSB=1 -> lane=0, else pass through. No other arithmetic.
// - Address wraps modulo 2^addr_w: base 0x7FF, 2 rows -> writes 0x7FF then 0x000.
// - Lane order is preserved: lane i = fifo_out[bw*i +: bw] -> sram_d[bw*i +: bw].
// - start while busy is ignored; job parameters are not re-sampled.
// - fifo_valid dropping during LAT/WRITE has no effect on the current row.
// - Reset mid-job (any state): immediate return to reset values.
//   - No partial write: sram_cen is high asynchronously.
//   - No done pulse.
// - sram_cen/sram_wen are high in every state except WRITE.
// STRUCTURE
// - Shared include drain_defs.vh: FSM state localparams (IDLE, WAIT, ISSUE, LAT, WRITE, DONE; 3-bit) and the default widths.
// - One sub-module relu_lane #(bw): combinational per-lane clamp, instantiated col times via generate.
// - Remaining logic lives in ofifo_drain:
//   - FSM
//   - rd_lat down-counter
//   - addr/cnt counters
//   - row capture register
// TESTING
// - Basic drain: base=0x010, num=3, relu_en=0, fifo_valid held 1, rows R0..R2.
//   - Expect exactly 3 fifo_rd pulses.
//   - Expect writes at 0x010/0x011/0x012 with D=R0..R2.
//   - Expect done pulse once; busy low the following cycle.
// - ReLU: relu_en=1, row lanes {0x8000,0xFFFF,0x0001,0x7FFF,...}.
//   - Expect sram_d lanes {0x0000,0x0000,0x0001,0x7FFF,...}.
//   - Same row with relu_en=0 passes unchanged.
// - Backpressure: num=2, fifo_valid low 10 cycles, then high.
//   - Expect no fifo_rd and sram_cen=1 throughout the gap.
//   - Expect the first fifo_rd the cycle after fifo_valid rises.
// - Boundaries:
//   - num_words=0 -> done 1 cycle after start, no fifo_rd, no write.
//   - base=0x7FF, num=2 -> addresses 0x7FF then 0x000.
//   - start pulsed while busy -> ignored, job count unchanged.
// - Reset mid-job: assert reset during LAT of row 1 of 4.
//   - Expect sram_cen=1 immediately, no done pulse, all outputs at reset values.
//   - A fresh start then completes a full 4-row job.
// - Latency: with rd_lat=2, the captured data must equal the fifo_out value 2 cycles after fifo_rd.
//   - Bench drives garbage at all other cycles.

Source files
------------

// File: rtl/ofifo_drain_pkg.sv
// Shared widths and FSM encodings for the ofifo drain engine.
// Imported by the drain top and its lane sub-module.
package ofifo_drain_pkg;

  localparam int COL_DEF    = 8;
  localparam int BW_DEF     = 16;
  localparam int ADDR_W_DEF = 11;
  localparam int RD_LAT_DEF = 2;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_WAIT  = 3'd1;
  localparam state_t S_ISSUE = 3'd2;
  localparam state_t S_LAT   = 3'd3;
  localparam state_t S_WRITE = 3'd4;
  localparam state_t S_DONE  = 3'd5;

endpackage

// File: rtl/ofifo_drain_relu_lane.sv
// Per-lane signed clamp: negative lanes go to zero when enabled.
// Purely combinational; instantiated once per column.
module relu_lane #(
  parameter int bw = 16
) (
  input  logic          en,
  input  logic [bw-1:0] din,
  output logic [bw-1:0] dout
);

  assign dout = (en && din[bw-1]) ? '0 : din;

endmodule

// File: rtl/ofifo_drain.sv
// Drains full rows from the output FIFO into the psum SRAM.
// One read in flight at a time; optional ReLU on the way.
module ofifo_drain
  import ofifo_drain_pkg::*;
#(
  parameter int col    = COL_DEF,
  parameter int bw     = BW_DEF,
  parameter int addr_w = ADDR_W_DEF,
  parameter int rd_lat = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [addr_w-1:0] base_addr,
  input  logic [addr_w-1:0] num_words,
  input  logic              relu_en,
  input  logic              fifo_valid,
  output logic              fifo_rd,
  input  logic [bw*col-1:0] fifo_out,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [addr_w-1:0] sram_a,
  output logic [bw*col-1:0] sram_d,
  output logic              busy,
  output logic              done
);

  localparam int LW = $clog2(rd_lat + 1);

  state_t state_q, state_d;

  logic [LW-1:0]     lat_q, lat_d;
  logic [addr_w-1:0] addr_q, addr_d;
  logic [addr_w-1:0] cnt_q, cnt_d;
  logic [addr_w-1:0] num_q, num_d;
  logic              relu_q, relu_d;

  logic              fifo_rd_q, fifo_rd_d;
  logic              sram_cen_q, sram_cen_d;
  logic              sram_wen_q, sram_wen_d;
  logic [addr_w-1:0] sram_a_q, sram_a_d;
  logic [bw*col-1:0] sram_d_q, sram_d_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [bw*col-1:0] row_proc;
  logic [addr_w-1:0] cnt_inc;

  for (genvar i = 0; i < col; i++) begin : g_lane
    relu_lane #(
      .bw(bw)
    ) u_lane (
      .en  (relu_q),
      .din (fifo_out[bw*i +: bw]),
      .dout(row_proc[bw*i +: bw])
    );
  end

  assign cnt_inc = cnt_q + addr_w'(1);

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    relu_d   = relu_q;
    sram_a_d = sram_a_q;
    sram_d_d = sram_d_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          addr_d  = base_addr;
          num_d   = num_words;
          relu_d  = relu_en;
          cnt_d   = '0;
          state_d = (num_words == '0) ? S_DONE : S_WAIT;
        end
      end
      (state_q == S_WAIT): begin
        if (fifo_valid) state_d = S_ISSUE;
      end
      (state_q == S_ISSUE): begin
        lat_d   = LW'(rd_lat);
        state_d = S_LAT;
      end
      (state_q == S_LAT): begin
        // Last latency cycle: fifo_out holds the popped row now.
        if (lat_q <= LW'(1)) begin
          sram_d_d = row_proc;
          sram_a_d = addr_q;
          state_d  = S_WRITE;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      (state_q == S_WRITE): begin
        addr_d  = addr_q + addr_w'(1);
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == num_q) ? S_DONE : S_WAIT;
      end
      (state_q == S_DONE): begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered.
  always_comb begin
    fifo_rd_d  = (state_d == S_ISSUE);
    sram_cen_d = (state_d != S_WRITE);
    sram_wen_d = (state_d != S_WRITE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      lat_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      num_q      <= '0;
      relu_q     <= 1'b0;
      fifo_rd_q  <= 1'b0;
      sram_cen_q <= 1'b1;
      sram_wen_q <= 1'b1;
      sram_a_q   <= '0;
      sram_d_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      relu_q     <= relu_d;
      fifo_rd_q  <= fifo_rd_d;
      sram_cen_q <= sram_cen_d;
      sram_wen_q <= sram_wen_d;
      sram_a_q   <= sram_a_d;
      sram_d_q   <= sram_d_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign fifo_rd  = fifo_rd_q;
  assign sram_cen = sram_cen_q;
  assign sram_wen = sram_wen_q;
  assign sram_a   = sram_a_q;
  assign sram_d   = sram_d_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ofifo_drain.sv
// Directed bench for ofifo_drain with a FIFO model and write scoreboard.
// Rows appear on fifo_out only in the read-latency slot; junk otherwise.
module tb_ofifo_drain;

  localparam int AW = 11;
  localparam int DW = 128;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_words = '0;
  logic          relu_en = 1'b0;
  logic          fifo_valid = 1'b0;
  logic [DW-1:0] fifo_out = '0;
  logic          fifo_rd;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic          busy;
  logic          done;

  wr_t           exp_q[$];
  logic [DW-1:0] src_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;

  logic          h1 = 1'b0;
  logic          h2 = 1'b0;
  logic          prev_done = 1'b0;
  logic          cur_relu = 1'b0;
  logic [AW-1:0] exp_addr = '0;

  logic [15:0]   lanes[8];
  logic [DW-1:0] relu_row;
  logic [DW-1:0] relu_exp;

  always #5 clk = ~clk;

  ofifo_drain dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .relu_en   (relu_en),
    .fifo_valid(fifo_valid),
    .fifo_rd   (fifo_rd),
    .fifo_out  (fifo_out),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [DW-1:0] junk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [DW-1:0] relu_model(
    input logic [DW-1:0] r,
    input logic          en
  );
    logic [DW-1:0] o;
    o = r;
    for (int i = 0; i < 8; i++)
      if (en && r[16*i+15]) o[16*i +: 16] = 16'h0000;
    return o;
  endfunction

  task automatic chk(
    input string         tag,
    input logic [DW-1:0] obs,
    input logic [DW-1:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc++;
    chk("wen_eq_cen", sram_wen, sram_cen);
    if (prev_done) chk("busy_after_done", busy, 1'b0);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_at_done", busy, 1'b1);
    end
    prev_done = done;
    if (fifo_rd) rd_cnt++;
    if (!sram_cen) begin
      wr_cnt++;
      chk("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", sram_a, e.a);
        chk("wr_data", sram_d, e.d);
      end
    end
    if (h2) begin
      chk("src_nonempty", src_q.size() != 0, 1'b1);
      if (src_q.size() != 0) begin
        fifo_out = src_q.pop_front();
        e.a = exp_addr;
        e.d = relu_model(fifo_out, cur_relu);
        exp_q.push_back(e);
        exp_addr++;
      end
    end else begin
      fifo_out = junk();
    end
    h2 = h1;
    h1 = fifo_rd;
  endtask

  task automatic start_job(
    input logic [AW-1:0] base,
    input logic [AW-1:0] num,
    input logic          relu
  );
    rd_cnt    = 0;
    wr_cnt    = 0;
    done_cnt  = 0;
    base_addr = base;
    num_words = num;
    relu_en   = relu;
    cur_relu  = relu;
    exp_addr  = base;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start     = 1'b0;
    base_addr = AW'($urandom());
    num_words = AW'($urandom());
    relu_en   = ~relu;
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (done_cnt == 0 && n < limit) begin
      tick();
      n++;
    end
    chk("done_seen", done_cnt != 0, 1'b1);
    tick();
    tick();
  endtask

  task automatic end_job(input int n);
    chk("rd_count", rd_cnt, n);
    chk("wr_count", wr_cnt, n);
    chk("done_count", done_cnt, 1);
    chk("sb_empty", exp_q.size(), 0);
    chk("src_empty", src_q.size(), 0);
  endtask

  task automatic push_rows(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(junk());
  endtask

  task automatic chk_reset_vals();
    chk("rst_fifo_rd", fifo_rd, 1'b0);
    chk("rst_cen", sram_cen, 1'b1);
    chk("rst_wen", sram_wen, 1'b1);
    chk("rst_a", sram_a, '0);
    chk("rst_d", sram_d, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
  endtask

  initial begin
    int n;
    lanes = '{16'h8000, 16'hFFFF, 16'h0001, 16'h7FFF,
              16'h1234, 16'hF000, 16'h0000, 16'h8001};
    for (int i = 0; i < 8; i++) relu_row[16*i +: 16] = lanes[i];
    relu_exp = relu_row;
    relu_exp[15:0]    = 16'h0000;
    relu_exp[31:16]   = 16'h0000;
    relu_exp[95:80]   = 16'h0000;
    relu_exp[127:112] = 16'h0000;

    repeat (3) tick();
    chk_reset_vals();
    reset = 1'b1;
    tick();
    chk_reset_vals();

    fifo_valid = 1'b1;
    push_rows(3);
    start_job(11'h010, 11'd3, 1'b0);
    wait_done(60);
    end_job(3);

    src_q.push_back(relu_row);
    start_job(11'h020, 11'd1, 1'b1);
    wait_done(30);
    end_job(1);
    chk("relu_lanes", sram_d, relu_exp);

    src_q.push_back(relu_row);
    start_job(11'h021, 11'd1, 1'b0);
    wait_done(30);
    end_job(1);
    chk("relu_off_pass", sram_d, relu_row);

    fifo_valid = 1'b0;
    push_rows(2);
    start_job(11'h300, 11'd2, 1'b0);
    repeat (10) tick();
    chk("bp_no_rd", rd_cnt, 0);
    chk("bp_no_wr", wr_cnt, 0);
    fifo_valid = 1'b1;
    tick();
    chk("bp_first_rd", fifo_rd, 1'b1);
    fifo_valid = 1'b0;
    repeat (3) tick();
    chk("bp_row0_written", wr_cnt, 1);
    repeat (4) tick();
    chk("bp_hold_rd", rd_cnt, 1);
    fifo_valid = 1'b1;
    wait_done(40);
    end_job(2);

    start_job(11'h123, 11'd0, 1'b0);
    chk("zero_done_lat", done_cyc - start_cyc, 1);
    wait_done(5);
    end_job(0);

    push_rows(2);
    start_job(11'h7FF, 11'd2, 1'b0);
    wait_done(40);
    end_job(2);
    chk("wrap_last_a", sram_a, 11'h000);

    push_rows(3);
    start_job(11'h200, 11'd3, 1'b0);
    repeat (4) tick();
    base_addr = 11'h100;
    num_words = 11'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(60);
    end_job(3);

    push_rows(4);
    start_job(11'h040, 11'd4, 1'b0);
    n = 0;
    while (rd_cnt < 2 && n < 40) begin
      tick();
      n++;
    end
    chk("rd2_seen", rd_cnt, 2);
    tick();
    reset = 1'b0;
    #1;
    chk_reset_vals();
    src_q.delete();
    exp_q.delete();
    h1 = 1'b0;
    h2 = 1'b0;
    done_cnt = 0;
    repeat (3) tick();
    chk("rst_no_done", done_cnt, 0);
    chk("rst_no_extra_wr", wr_cnt, 1);
    chk_reset_vals();
    reset = 1'b1;
    tick();

    push_rows(4);
    start_job(11'h050, 11'd4, 1'b0);
    wait_done(80);
    end_job(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
